// File: rtl/mvu_pkg.sv
// Shared types and geometry helpers for the MVU weight streamer.
package mvu_pkg;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

   function automatic int calc_sf(input int matrix_w, input int simd);
      return matrix_w / simd;
   endfunction

   function automatic int calc_nf(input int matrix_h, input int pe);
      return matrix_h / pe;
   endfunction

   function automatic int calc_depth(input int sf, input int nf);
      return sf * nf;
   endfunction

   // A single-word memory still needs a 1-bit address port.
   function automatic int calc_addr_w(input int depth);
      return (depth <= 1) ? 1 : $clog2(depth);
   endfunction

endpackage

// File: rtl/mvu_wgt_streamer_if.sv
// Weight-memory read bus plus the valid/ready weight stream towards the MVU.
interface mvu_wgt_streamer_if #(
   parameter int WW     = 4,
   parameter int ADDR_W = 2
);
   logic              wmem_en;
   logic [ADDR_W-1:0] wmem_addr;
   logic [0:WW-1]     wmem_rdata;
   logic              out_wgt_v;
   logic              out_wgt_ready;
   logic [0:WW-1]     out_wgt;

   modport master (
      output wmem_en, wmem_addr, out_wgt_v, out_wgt,
      input  wmem_rdata, out_wgt_ready
   );

   modport slave (
      input  wmem_en, wmem_addr, out_wgt_v, out_wgt,
      output wmem_rdata, out_wgt_ready
   );
endinterface

// File: rtl/mvu_skid_fifo2.sv
// Two-entry skid FIFO; slot0 is always the head, same-cycle push and pop allowed.
module mvu_skid_fifo2 #(
   parameter int W = 4
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         push,
   input  logic [0:W-1] din,
   input  logic         pop,
   output logic [0:W-1] dout,
   output logic [1:0]   count,
   output logic         full,
   output logic         empty
);
   logic [0:W-1] slot0, slot1;
   logic         do_push, do_pop;

   assign empty   = (count == 2'd0);
   assign full    = (count == 2'd2);
   assign dout    = slot0;
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         slot0 <= '0;
         slot1 <= '0;
         count <= 2'd0;
      end else begin
         case ({do_push, do_pop})
            2'b10: begin
               if (empty) slot0 <= din;
               else       slot1 <= din;
               count <= count + 2'd1;
            end
            2'b01: begin
               slot0 <= slot1;
               count <= count - 2'd1;
            end
            2'b11: begin
               if (count == 2'd1) begin
                  slot0 <= din;
               end else begin
                  slot0 <= slot1;
                  slot1 <= din;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: rtl/mvu_wgt_streamer.sv
// Streams the weight memory in tile order, reps times, onto the MVU weight input.
module mvu_wgt_streamer
   import mvu_pkg::*;
#(
   parameter int MatrixW = 8,
   parameter int MatrixH = 2,
   parameter int SIMD    = 2,
   parameter int PE      = 2,
   parameter int TW      = 1,
   parameter int REP_W   = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [REP_W-1:0] reps,
   output logic             busy,
   output logic             done,
   mvu_wgt_streamer_if.master wif
);
   localparam int SF     = calc_sf(MatrixW, SIMD);
   localparam int NF     = calc_nf(MatrixH, PE);
   localparam int DEPTH  = calc_depth(SF, NF);
   localparam int WW     = PE * SIMD * TW;
   localparam int ADDR_W = calc_addr_w(DEPTH);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   state_t            state, state_nxt;
   logic [REP_W-1:0]  reps_q, rep_cnt;
   logic [ADDR_W-1:0] addr;
   logic              inflight, issue, pop, push;
   logic [1:0]        occ;
   logic              fifo_full, fifo_empty;
   logic [2:0]        load;

   assign pop  = wif.out_wgt_v & wif.out_wgt_ready;
   assign push = inflight & (~fifo_full | pop);
   // Words already committed to the consumer side once this cycle's pop retires.
   assign load = {1'b0, occ} + {2'b0, inflight} - {2'b0, pop};

   assign busy          = (state != IDLE);
   assign done          = (state == FIN);
   assign wif.wmem_en   = issue;
   assign wif.wmem_addr = addr;
   assign wif.out_wgt_v = ~fifo_empty;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         reps_q   <= '0;
         rep_cnt  <= '0;
         addr     <= '0;
         inflight <= 1'b0;
      end else begin
         state    <= state_nxt;
         inflight <= issue;
         if (state == IDLE && start) begin
            reps_q  <= reps;
            rep_cnt <= '0;
            addr    <= '0;
         end else if (issue) begin
            if (addr == LAST_ADDR) begin
               addr    <= '0;
               rep_cnt <= rep_cnt + REP_W'(1);
            end else begin
               addr <= addr + ADDR_W'(1);
            end
         end
      end
   end

   always_comb begin
      state_nxt = state;
      issue     = 1'b0;
      case (state)
         IDLE:
            if (start) state_nxt = (reps == '0) ? FIN : RUN;
         RUN: begin
            issue = (load < 3'd2);
            if (issue && addr == LAST_ADDR && rep_cnt == reps_q - REP_W'(1))
               state_nxt = DRAIN;
         end
         // Finish as soon as the last word leaves, so done lands right after its handshake.
         DRAIN:
            if (!inflight && (occ == 2'd0 || (occ == 2'd1 && pop)))
               state_nxt = FIN;
         FIN:
            state_nxt = IDLE;
         default:
            state_nxt = IDLE;
      endcase
   end

   mvu_skid_fifo2 #(.W(WW)) u_fifo (
      .clock (clock),
      .reset (reset),
      .push  (push),
      .din   (wif.wmem_rdata),
      .pop   (pop),
      .dout  (wif.out_wgt),
      .count (occ),
      .full  (fifo_full),
      .empty (fifo_empty)
   );
endmodule

// File: tb/tb_mvu_wgt_streamer.sv
// Directed and randomized runs of the weight streamer against a word-sequence model.
module tb_mvu_wgt_streamer;
   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        start0 = 1'b0, start1 = 1'b0;
   logic [15:0] reps0 = '0, reps1 = '0;
   logic        busy0, done0, busy1, done1;
   logic        rdy0 = 1'b0, rdy1 = 1'b0;
   logic [0:3]  rd0 = '0, rd1 = '0;
   logic [0:3]  mem0 [4];
   logic [0:3]  mem1 [2];
   int          npass = 0, ntot = 0;

   always #5 clock = ~clock;

   mvu_wgt_streamer_if #(.WW(4), .ADDR_W(2)) if0 ();
   mvu_wgt_streamer_if #(.WW(4), .ADDR_W(1)) if1 ();

   mvu_wgt_streamer dut0 (
      .clock(clock), .reset(reset), .start(start0), .reps(reps0),
      .busy(busy0), .done(done0), .wif(if0)
   );

   mvu_wgt_streamer #(.MatrixW(2), .MatrixH(2)) dut1 (
      .clock(clock), .reset(reset), .start(start1), .reps(reps1),
      .busy(busy1), .done(done1), .wif(if1)
   );

   // Synchronous weight memories: data is valid the cycle after the enable is sampled.
   always @(posedge clock) if (if0.wmem_en) rd0 <= mem0[if0.wmem_addr];
   always @(posedge clock) if (if1.wmem_en) rd1 <= mem1[if1.wmem_addr];
   assign if0.wmem_rdata    = rd0;
   assign if1.wmem_rdata    = rd1;
   assign if0.out_wgt_ready = rdy0;
   assign if1.out_wgt_ready = rdy1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ntot++;
      assert (obs === exp) npass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // mode 0: ready high; 1: low 5 cycles after first valid then toggling; 2: random.
   task automatic run(input bit sel, input int nreps, input int mode, input bit repulse,
                      input int abort_hs, input string tag);
      logic [0:3] exp_q[$];
      logic [0:3] got_q[$];
      int depth, first_v, first_hs, last_hs, done_n, done_c, en_n, v_n;
      int addr_err, stab_err, busy_err, max_out, issued, popped, word_err;
      bit pv_stall, aborted, r;
      logic [0:3] pword, w;
      logic v, en, dn, bs;
      logic [1:0] ad;
      depth = sel ? 1 : 4;
      first_v = -1; first_hs = -1; last_hs = -1; done_n = 0; done_c = -1;
      en_n = 0; v_n = 0; addr_err = 0; stab_err = 0; busy_err = 0; max_out = 0;
      issued = 0; popped = 0; word_err = 0; pv_stall = 0; aborted = 0; pword = '0;
      for (int rep = 0; rep < nreps; rep++)
         for (int a = 0; a < depth; a++)
            exp_q.push_back(sel ? mem1[0] : mem0[a]);
      @(negedge clock);
      if (sel) begin start1 = 1'b1; reps1 = 16'(nreps); end
      else     begin start0 = 1'b1; reps0 = 16'(nreps); end
      @(negedge clock);
      for (int c = 1; c <= 400; c++) begin
         if (c > 1) @(negedge clock);
         start0 = 1'b0; start1 = 1'b0;
         if (repulse && c == 3) begin start0 = 1'b1; reps0 = 16'd5; end
         case (mode)
            0: r = 1'b1;
            1: r = (first_v >= 0 && c >= first_v + 5) ? ((c - first_v - 5) % 2 == 0) : 1'b0;
            default: r = 1'($urandom_range(0, 1));
         endcase
         if (sel) rdy1 = r; else rdy0 = r;
         #1;
         if (sel) begin v = if1.out_wgt_v; w = if1.out_wgt; en = if1.wmem_en;
                        ad = {1'b0, if1.wmem_addr}; dn = done1; bs = busy1; end
         else     begin v = if0.out_wgt_v; w = if0.out_wgt; en = if0.wmem_en;
                        ad = if0.wmem_addr; dn = done0; bs = busy0; end
         if (pv_stall && (!v || w !== pword)) stab_err++;
         pv_stall = v && !r;
         pword = w;
         if (v && first_v < 0) first_v = c;
         if (v) v_n++;
         if (en) begin
            if (int'(ad) != issued % depth) addr_err++;
            issued++; en_n++;
         end
         if (v && r) begin
            got_q.push_back(w); popped++;
            if (first_hs < 0) first_hs = c;
            last_hs = c;
         end
         if (issued - popped > max_out) max_out = issued - popped;
         if (done_c >= 0 && c == done_c + 1 && bs) busy_err++;
         if (dn) begin done_n++; done_c = c; end
         if (done_c < 0 && !bs) busy_err++;
         if (abort_hs > 0 && popped == abort_hs) begin aborted = 1'b1; break; end
         if (done_c >= 0 && c >= done_c + 2) break;
      end
      if (!aborted) begin
         for (int i = 0; i < exp_q.size(); i++)
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) word_err++;
         chk({tag, ".done_count"}, done_n, 1);
         chk({tag, ".word_count"}, got_q.size(), exp_q.size());
         chk({tag, ".word_errors"}, word_err, 0);
         chk({tag, ".busy_errors"}, busy_err, 0);
         chk({tag, ".outstanding_le2"}, 32'(max_out <= 2), 1);
         if (nreps == 0) begin
            chk({tag, ".done_cycle"}, done_c, 1);
            chk({tag, ".wmem_en_count"}, en_n, 0);
            chk({tag, ".valid_count"}, v_n, 0);
         end else begin
            chk({tag, ".first_valid"}, first_v, 3);
            chk({tag, ".done_after_hs"}, done_c, last_hs + 1);
            chk({tag, ".addr_errors"}, addr_err, 0);
            chk({tag, ".stall_errors"}, stab_err, 0);
            if (mode == 0) chk({tag, ".no_bubbles"}, last_hs - first_hs + 1, exp_q.size());
         end
      end
   endtask

   initial begin
      int dn_seen;
      for (int a = 0; a < 4; a++) mem0[a] = 4'(a + 1);
      mem1[0] = 4'h9; mem1[1] = 4'h0;
      #12;
      chk("reset.outputs0", {busy0, done0, if0.wmem_en, if0.wmem_addr, if0.out_wgt_v, if0.out_wgt}, 0);
      chk("reset.outputs1", {busy1, done1, if1.wmem_en, if1.wmem_addr, if1.out_wgt_v, if1.out_wgt}, 0);
      @(negedge clock); reset = 1'b0;

      run(0, 2, 0, 0, 0, "reps2");
      run(0, 1, 1, 0, 0, "stall");
      run(0, 0, 0, 0, 0, "reps0");
      run(0, 2, 0, 1, 0, "restart_ignored");

      run(0, 2, 0, 0, 3, "abort");
      reset = 1'b1;
      #1;
      chk("midrun_reset.outputs", {busy0, done0, if0.wmem_en, if0.wmem_addr, if0.out_wgt_v, if0.out_wgt}, 0);
      dn_seen = 0;
      repeat (2) begin @(negedge clock); if (done0) dn_seen++; end
      reset = 1'b0;
      repeat (5) begin @(negedge clock); if (done0) dn_seen++; end
      chk("midrun_reset.no_done", dn_seen, 0);
      run(0, 1, 0, 0, 0, "after_reset");

      run(1, 3, 0, 0, 0, "depth1");

      for (int k = 0; k < 3; k++) begin
         for (int a = 0; a < 4; a++) mem0[a] = 4'($urandom);
         run(0, int'($urandom_range(1, 3)), 2, 0, 0, $sformatf("random%0d", k));
      end

      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end
endmodule

// File: doc/mvu_wgt_streamer.md
Name: mvu_wgt_streamer

Overview:
- Transmitter for the weight stream consumed by the MVU stream unit.
- Reads packed PE x SIMD weight words from an external synchronous weight memory in tile order, once per repetition.
- Presents them on a valid/ready interface that connects directly to the MVU's in_wgt_v / wmem_wready / in_wgt inputs.
- Absorbs consumer back-pressure with a 2-entry skid FIFO and sustains one word per cycle when unstalled.

Parameters:
- MatrixW, 8: matrix width (input columns).
- MatrixH, 2: matrix height (output rows).
- SIMD, 2: columns per word.
- PE, 2: rows per word.
- TW, 1: weight bit width.
- REP_W, 16: width of repetition count.
- Derived: SF=MatrixW/SIMD, NF=MatrixH/PE, DEPTH=SF*NF, WW=PE*SIMD*TW, ADDR_W=max(1,$clog2(DEPTH)).

Ports:
- clock  in  1  sole clock.
- reset  in  1  asynchronous, active-high.
- start  in  1  begin a run; sampled only in IDLE.
- reps  in  REP_W  number of full passes over the weight memory; latched on start.
- busy  out  1  high from the start-accept edge until done.
- done  out  1  one-cycle pulse at run completion.
- wmem_en  out  1  read enable to weight memory.
- wmem_addr  out  ADDR_W  read address.
- wmem_rdata  in  WW  read data, valid the cycle after wmem_en is sampled.
- out_wgt_v  out  1  weight word valid; connects to the MVU's in_wgt_v.
- out_wgt_ready  in  1  consumer ready; connects to the MVU's wmem_wready.
- out_wgt  out  [0:WW-1]  weight word; PE0 occupies bits 0..SIMD*TW-1, passed through unmodified from memory.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset value of every output is 0, including busy, done, wmem_en, wmem_addr, out_wgt_v and out_wgt. FIFO occupancy, in-flight flag, address counter and rep counter all clear.
- Reset mid-run abandons the run with no done pulse. The next start restarts from address 0.
- FSM states:
  - IDLE: on start with reps==0, go to FIN. On start with reps!=0, latch reps, clear the address and rep counters, and go to RUN.
  - RUN: issue reads. After issuing address DEPTH-1 of the final rep, go to DRAIN.
  - DRAIN: no reads. When the FIFO is empty and no read is in flight, go to FIN.
  - FIN: pulse done for one cycle, then go to IDLE.
- busy = (state != IDLE). start is ignored unless the state is IDLE.
- Word order: address a = nf*SF + sf, with sf the inner index and nf the outer index. The address wraps from DEPTH-1 to 0. Each wrap increments the rep counter.
- Issue rule (RUN only): wmem_en = (occupancy + inflight - pop) < 2, where pop = out_wgt_v & out_wgt_ready.
  - wmem_addr is valid whenever wmem_en is high.
  - The address advances on every issue.
- In-flight handling: inflight is a 1-bit flag set on issue. Returned data is pushed into the FIFO on the edge after wmem_rdata becomes valid. The push rule guarantees the FIFO never overflows. Push and pop in the same cycle is legal.
- Output side:
  - out_wgt_v = FIFO non-empty; out_wgt = FIFO head.
  - While out_wgt_v & ~out_wgt_ready, out_wgt is held stable and out_wgt_v stays high.
  - A word is never dropped or duplicated.
- Latency: with start sampled at edge N, the address-0 read is sampled at edge N+1 and out_wgt_v goes high after edge N+2.
- Throughput: with out_wgt_ready held high, one word per cycle with no bubbles, including across address wrap and rep boundaries.
- done asserts the cycle after the final handshake of the run. For reps==0, done asserts the cycle after the start-accept edge and wmem_en is never asserted.
- Counters: the rep counter is REP_W bits wide, and reps = 2^REP_W-1 is supported.

Decomposition:
- Package mvu_pkg holds:
  - the state enum (IDLE, RUN, DRAIN, FIN);
  - functions computing SF, NF, DEPTH and ADDR_W.
- One sub-module, mvu_skid_fifo2, parameterised by width: a 2-entry FIFO with push/pop, occupancy count, full and empty flags, and same-cycle push+pop support.

Test Plan:
- Defaults (DEPTH=4, WW=4), memory word at address a = a+1. reps=2, ready held high -> out_wgt sequence 1,2,3,4,1,2,3,4 on consecutive cycles; first valid 2 cycles after start; done one cycle after the last handshake; busy then low.
- reps=1, ready low for 5 cycles after first valid, then toggled 1/0 -> word 1 held stable while stalled; sequence exactly 1,2,3,4; FIFO occupancy + in-flight never exceeds 2.
- reps=0 -> done pulses the cycle after start; wmem_en never high; out_wgt_v never high.
- start re-pulsed during RUN with reps=5 -> ignored; the original run completes with 8 words (reps=2) and a single done.
- reset asserted after the 3rd handshake -> all outputs 0 immediately and no done. A following start with reps=1 -> sequence 1,2,3,4 from address 0.
- MatrixW=SIMD, MatrixH=PE (DEPTH=1), reps=3, ready high -> wmem_addr constant 0, three back-to-back words, done once.
